aes_mix_column_engine: RTL and testbench

//  Sequential, parametrised MixColumns/InvMixColumns unit for the AES round datapath.

---
 rtl/aes_mix_column_engine.sv | 137 +++++++++++++
 tb/tb_aes_mix_column_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_mix_column_engine.sv
// Iterative AES MixColumns/InvMixColumns engine: a 128-bit state is latched on accept and
// transformed COLS_PER_CYCLE columns per clock in place, then held until the consumer takes it.

module aes_mc_lane #(
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, x2, fwd, bwd;

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign a[r]   = col[8*r +: 8];
    assign x2[r]  = xt(a[r]);
    assign fwd[r] = x2[r] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3];
  end

  if (SUPPORT_INV) begin : g_inv
    // 0e/0b/0d/09 products assembled from the shared x2 -> x4 -> x8 chain
    logic [3:0][7:0] x4, x8, m9, mb, md, me;
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int R1 = (r + 1) % 4;
      localparam int R2 = (r + 2) % 4;
      localparam int R3 = (r + 3) % 4;
      assign x4[r]  = xt(x2[r]);
      assign x8[r]  = xt(x4[r]);
      assign m9[r]  = x8[r] ^ a[r];
      assign mb[r]  = x8[r] ^ x2[r] ^ a[r];
      assign md[r]  = x8[r] ^ x4[r] ^ a[r];
      assign me[r]  = x8[r] ^ x4[r] ^ x2[r];
      assign bwd[r] = me[r] ^ mb[R1] ^ md[R2] ^ m9[R3];
    end
    assign res = inv ? bwd : fwd;
  end else begin : g_fwd_only
    logic unused_inv;
    assign unused_inv = inv;
    assign bwd        = '0;
    assign res        = fwd;
  end
endmodule

module aes_mix_column_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit SUPPORT_INV    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_aes_mix_column_valid,
  output logic         o_aes_mix_column_ready,
  input  logic [127:0] i_aes_mix_column_data_in,
  input  logic         i_aes_mix_column_inverse,
  output logic         o_aes_mix_column_valid,
  input  logic         i_aes_mix_column_ready,
  output logic [127:0] o_aes_mix_column_data_out,
  output logic         o_aes_mix_column_busy
);
  localparam int NUM_LANES = COLS_PER_CYCLE;

  if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_cols
    $error("aes_mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(NUM_LANES % 4);
  localparam logic [1:0] LAST = 2'(4 - NUM_LANES);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] data_q;
  logic [1:0]   cnt_q;
  logic         inv_q;
  logic         accept;

  logic [NUM_LANES-1:0][1:0]  col_idx;
  logic [NUM_LANES-1:0][31:0] col_in, col_out;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign col_idx[l] = cnt_q + 2'(l);
    assign col_in[l]  = data_q[32*col_idx[l] +: 32];
    aes_mc_lane #(.SUPPORT_INV(SUPPORT_INV)) u_lane (
      .col (col_in[l]),
      .inv (inv_q),
      .res (col_out[l])
    );
  end

  always_comb begin
    state_d                = state_q;
    o_aes_mix_column_ready = 1'b0;
    accept                 = 1'b0;
    unique case (state_q)
      IDLE:    o_aes_mix_column_ready = !rst;
      DONE:    o_aes_mix_column_ready = !rst && i_aes_mix_column_ready;
      default: o_aes_mix_column_ready = 1'b0;
    endcase
    accept = i_aes_mix_column_valid && o_aes_mix_column_ready;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (i_aes_mix_column_ready) state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= i_aes_mix_column_data_in;
        inv_q  <= SUPPORT_INV && i_aes_mix_column_inverse;
        cnt_q  <= '0;
      end else if (state_q == CALC) begin
        for (int l = 0; l < NUM_LANES; l++)
          data_q[32*col_idx[l] +: 32] <= col_out[l];
        cnt_q <= cnt_q + STEP;
      end
    end
  end

  // Partial results never leak out while columns are still being rewritten
  assign o_aes_mix_column_valid    = (state_q == DONE);
  assign o_aes_mix_column_busy     = (state_q != IDLE);
  assign o_aes_mix_column_data_out = o_aes_mix_column_valid ? data_q : '0;
endmodule

// File: tb/tb_aes_mix_column_engine.sv
// Bench for aes_mix_column_engine: three instances (1, 2, 4 columns/cycle) share stimulus;
// results are compared against a GF(2^8) matrix-product model.

module tb_aes_mix_column_engine;
  logic         clk = 1'b0;
  logic         rst, vld, rdy_in, inv;
  logic [127:0] din;
  logic [2:0]   ordy, ov, ob;
  logic [127:0] od [3];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  aes_mix_column_engine #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1'b1)) u_c1 (
    .clk(clk), .rst(rst), .i_aes_mix_column_valid(vld), .o_aes_mix_column_ready(ordy[0]),
    .i_aes_mix_column_data_in(din), .i_aes_mix_column_inverse(inv),
    .o_aes_mix_column_valid(ov[0]), .i_aes_mix_column_ready(rdy_in),
    .o_aes_mix_column_data_out(od[0]), .o_aes_mix_column_busy(ob[0]));
  aes_mix_column_engine #(.COLS_PER_CYCLE(2), .SUPPORT_INV(1'b1)) u_c2 (
    .clk(clk), .rst(rst), .i_aes_mix_column_valid(vld), .o_aes_mix_column_ready(ordy[1]),
    .i_aes_mix_column_data_in(din), .i_aes_mix_column_inverse(inv),
    .o_aes_mix_column_valid(ov[1]), .i_aes_mix_column_ready(rdy_in),
    .o_aes_mix_column_data_out(od[1]), .o_aes_mix_column_busy(ob[1]));
  aes_mix_column_engine #(.COLS_PER_CYCLE(4), .SUPPORT_INV(1'b1)) u_c4 (
    .clk(clk), .rst(rst), .i_aes_mix_column_valid(vld), .o_aes_mix_column_ready(ordy[2]),
    .i_aes_mix_column_data_in(din), .i_aes_mix_column_inverse(inv),
    .o_aes_mix_column_valid(ov[2]), .i_aes_mix_column_ready(rdy_in),
    .o_aes_mix_column_data_out(od[2]), .o_aes_mix_column_busy(ob[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [8:0] t;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      t = {a, 1'b0};
      if (t[8]) t ^= 9'h11b;
      a = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic m);
    logic [7:0] cf [4];
    logic [7:0] acc;
    logic [127:0] r = '0;
    if (m) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else   begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(s[8*(4*c + (row + j) % 4) +: 8], cf[j]);
        r[8*(4*c + row) +: 8] = acc;
      end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    #1;
    while (!ordy[k] && n < 50) begin tick(); n++; end
    if (!ordy[k]) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut=%0d ready=%b required 1", k, ordy[k]);
    end
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!ov[k] && lat < 50);
    if (!ov[k]) begin
      checks++; errors++;
      $display("FAIL valid_timeout dut=%0d valid=%b required 1", k, ov[k]);
    end
  endtask

  task automatic do_txn(input int k, input logic [127:0] s, input logic m,
                        output logic [127:0] res, output int lat);
    rdy_in = 1'b1; vld = 1'b1; din = s; inv = m;
    wait_ready(k);
    tick();
    vld = 1'b0;
    wait_valid(k, lat);
    res = od[k];
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; rdy_in = 1'b0; inv = 1'b0; din = '0;
    tick(); tick();
    checks++; if (ov !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", ov); end
    checks++; if (ob !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", ob); end
    checks++; if (od[0] !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", od[0]); end
    checks++; if (ordy !== 3'b000) begin errors++; $display("FAIL reset_ready_in_rst got %b exp 000", ordy); end
    rst = 1'b0; #1;
    checks++; if (ordy !== 3'b111) begin errors++; $display("FAIL reset_ready_after got %b exp 111", ordy); end
  endtask

  task automatic test_vectors();
    logic [127:0] r;
    int lat;
    do_txn(0, 128'he598271ef11141b8ae52b4e0305dbfd4, 1'b0, r, lat);
    checks++; if (r !== 128'h4c2606287ad3f8489a19cbe0e5816604) begin errors++; $display("FAIL vec1_data got %h exp 4c2606287ad3f8489a19cbe0e5816604", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL vec1_latency got %0d exp 4", lat); end
    do_txn(0, 128'h4c2606287ad3f8489a19cbe0e5816604, 1'b1, r, lat);
    checks++; if (r !== 128'he598271ef11141b8ae52b4e0305dbfd4) begin errors++; $display("FAIL vec2_inv_data got %h exp e598271ef11141b8ae52b4e0305dbfd4", r); end
    do_txn(2, 128'hc6c6c6c6010101015c220af2455313db, 1'b0, r, lat);
    checks++; if (r !== 128'hc6c6c6c6010101019d58dc9fbca14d8e) begin errors++; $display("FAIL vec3_c4_data got %h exp c6c6c6c6010101019d58dc9fbca14d8e", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL vec3_c4_latency got %0d exp 1", lat); end
    repeat (6) tick();
    do_txn(1, 128'hc6c6c6c6010101015c220af2455313db, 1'b0, r, lat);
    checks++; if (r !== 128'hc6c6c6c6010101019d58dc9fbca14d8e) begin errors++; $display("FAIL vec3_c2_data got %h exp c6c6c6c6010101019d58dc9fbca14d8e", r); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL vec3_c2_latency got %0d exp 2", lat); end
    repeat (6) tick();
  endtask

  task automatic test_random();
    logic [127:0] s, r;
    logic m;
    int lat, k;
    for (int i = 0; i < 12; i++) begin
      k = i % 3;
      s = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      do_txn(k, s, m, r, lat);
      checks++; if (r !== model(s, m)) begin errors++; $display("FAIL random_data dut=%0d inv=%0d got %h exp %h", k, m, r, model(s, m)); end
      checks++; if (lat !== (4 >> k)) begin errors++; $display("FAIL random_latency dut=%0d got %0d exp %0d", k, lat, 4 >> k); end
      repeat (6) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    int lat;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    rdy_in = 1'b0; vld = 1'b1; din = a; inv = 1'b0;
    wait_ready(0);
    tick();
    din = b; inv = 1'b1;
    wait_valid(0, lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got %b exp 1", i, ov[0]); end
      checks++; if (od[0] !== model(a, 1'b0)) begin errors++; $display("FAIL bp_data cyc=%0d got %h exp %h", i, od[0], model(a, 1'b0)); end
      checks++; if (ordy[0] !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got %b exp 0", i, ordy[0]); end
      tick();
    end
    rdy_in = 1'b1; #1;
    checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ordy[0]); end
    tick();
    vld = 1'b0; inv = 1'b0;
    wait_valid(0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", lat); end
    checks++; if (od[0] !== model(b, 1'b1)) begin errors++; $display("FAIL b2b_data got %h exp %h", od[0], model(b, 1'b1)); end
    tick();
    repeat (6) tick();
  endtask

  task automatic test_mode_latch();
    logic [127:0] s;
    logic m;
    int n;
    for (int t = 0; t < 2; t++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      m = 1'(t);
      rdy_in = 1'b1; vld = 1'b1; din = s; inv = m;
      wait_ready(0);
      tick();
      vld = 1'b0; n = 0;
      while (!ov[0] && n < 50) begin inv = ~inv; tick(); n++; end
      checks++; if (od[0] !== model(s, m)) begin errors++; $display("FAIL mode_latch inv=%0d got %h exp %h", m, od[0], model(s, m)); end
      tick();
      repeat (6) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] r;
    int lat;
    rdy_in = 1'b1; vld = 1'b1; din = 128'he598271ef11141b8ae52b4e0305dbfd4; inv = 1'b0;
    wait_ready(0);
    tick();
    vld = 1'b0;
    tick(); tick();
    checks++; if (ob[0] !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", ob[0]); end
    rst = 1'b1;
    tick();
    checks++; if (ov !== 3'b000) begin errors++; $display("FAIL mid_reset_valid got %b exp 000", ov); end
    checks++; if (od[0] !== '0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", od[0]); end
    checks++; if (ob !== 3'b000) begin errors++; $display("FAIL mid_reset_busy got %b exp 000", ob); end
    rst = 1'b0; #1;
    checks++; if (ordy[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", ordy[0]); end
    do_txn(0, 128'he598271ef11141b8ae52b4e0305dbfd4, 1'b0, r, lat);
    checks++; if (r !== 128'h4c2606287ad3f8489a19cbe0e5816604) begin errors++; $display("FAIL mid_reset_next got %h exp 4c2606287ad3f8489a19cbe0e5816604", r); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_mode_latch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
